// File: rtl/reversi_pkg.sv
// Shared cell encodings, error codes, FSM states and sizing helpers for the piece placer.
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_BLACK = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_OCCUPIED = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Word address width; never below 1 bit so tiny boards still get a real port.
  function automatic int addr_width(input int w, input int h, input int cpw);
    int words;
    words = (w * h + cpw - 1) / cpw;
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

  function automatic logic [1:0] piece_code(input logic black);
    return black ? CELL_BLACK : CELL_WHITE;
  endfunction

endpackage

// File: rtl/place_piece_rmw_if.sv
// Request/status handshake plus board RAM port of the piece placer.
interface place_piece_rmw_if #(
  parameter int XW     = 3,
  parameter int YW     = 3,
  parameter int DATA_W = 4,
  parameter int AW     = 5
);
  logic              place_req;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              player_black;
  logic [DATA_W-1:0] q;
  logic              wren;
  logic [AW-1:0]     address;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              place_done;
  logic              place_err;
  logic [1:0]        err_code;

  modport master (
    output place_req, x, y, player_black, q,
    input  wren, address, data, busy, place_done, place_err, err_code
  );

  modport slave (
    input  place_req, x, y, player_black, q,
    output wren, address, data, busy, place_done, place_err, err_code
  );
endinterface

// File: rtl/reversi_cell_merge.sv
// Replaces one 2-bit slot of a packed board word with a piece code and reports the old slot value.
module reversi_cell_merge #(
  parameter int CELLS_PER_WORD = 2,
  parameter int DATA_W         = 2 * CELLS_PER_WORD,
  parameter int SLW            = (CELLS_PER_WORD > 1) ? $clog2(CELLS_PER_WORD) : 1
) (
  input  logic [DATA_W-1:0] word,
  input  logic [SLW-1:0]    slot,
  input  logic [1:0]        piece,
  output logic [DATA_W-1:0] merged,
  output logic [1:0]        old
);
  import reversi_pkg::*;

  always_comb begin
    merged = word;
    old    = CELL_EMPTY;
    for (int s = 0; s < CELLS_PER_WORD; s++) begin
      if (slot == SLW'(s)) begin
        merged[2*s +: 2] = piece;
        old              = word[2*s +: 2];
      end
    end
  end

endmodule

// File: rtl/place_piece_rmw.sv
// Bounds-checked read-modify-write of one board cell with configurable RAM read latency.
// Optional occupied-cell rejection is enabled by defining REVERSI_OCCUPIED_CHECK_EN.
module place_piece_rmw
  import reversi_pkg::*;
#(
  parameter int BOARD_W        = 8,
  parameter int BOARD_H        = 8,
  parameter int CELLS_PER_WORD = 2,
  parameter int RD_LATENCY     = 1
) (
  input  logic             clk,
  input  logic             resetn,
  place_piece_rmw_if.slave bus
);

  localparam int XW     = $clog2(BOARD_W);
  localparam int YW     = $clog2(BOARD_H);
  localparam int DATA_W = 2 * CELLS_PER_WORD;
  localparam int AW     = addr_width(BOARD_W, BOARD_H, CELLS_PER_WORD);
  localparam int SW     = $clog2(CELLS_PER_WORD);
  localparam int SLW    = (CELLS_PER_WORD > 1) ? SW : 1;
  localparam int IW     = $clog2(BOARD_W * BOARD_H) + 1;

  localparam logic [XW:0] X_LIM = (XW + 1)'(BOARD_W);
  localparam logic [YW:0] Y_LIM = (YW + 1)'(BOARD_H);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [SLW-1:0]    slot_q, slot_d;
  logic              black_q, black_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        err_q, err_d;

  logic [IW-1:0]     idx;
  logic [AW-1:0]     word_addr;
  logic [SLW-1:0]    slot_sel;
  logic              out_of_range;
  logic [DATA_W-1:0] merged;
  logic [1:0]        old_cell;

  always_comb begin
    idx          = IW'(bus.y) * IW'(BOARD_W) + IW'(bus.x);
    word_addr    = AW'(idx >> SW);
    slot_sel     = SLW'(idx & IW'(CELLS_PER_WORD - 1));
    out_of_range = ({1'b0, bus.x} >= X_LIM) || ({1'b0, bus.y} >= Y_LIM);
  end

  // q is merged combinationally so the write word is ready on the sampling edge.
  reversi_cell_merge #(
    .CELLS_PER_WORD(CELLS_PER_WORD)
  ) u_merge (
    .word  (bus.q),
    .slot  (slot_q),
    .piece (piece_code(black_q)),
    .merged(merged),
    .old   (old_cell)
  );

`ifndef REVERSI_OCCUPIED_CHECK_EN
  logic unused_old;
  assign unused_old = ^old_cell;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      black_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      black_q <= black_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    black_d = black_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.place_req) begin
          black_d = bus.player_black;
          if (out_of_range) begin
            err_d   = ERR_RANGE;
            state_d = ST_FINISH;
          end else begin
            err_d   = ERR_NONE;
            addr_d  = word_addr;
            slot_d  = slot_sel;
            cnt_d   = 3'(RD_LATENCY);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
`ifdef REVERSI_OCCUPIED_CHECK_EN
          if (old_cell != CELL_EMPTY) begin
            err_d   = ERR_OCCUPIED;
            state_d = ST_FINISH;
          end else begin
            data_d  = merged;
            state_d = ST_WRITE;
          end
`else
          data_d  = merged;
          state_d = ST_WRITE;
`endif
        end
      end
      ST_WRITE:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so a reset edge drops them all at once.
  always_comb begin
    bus.wren       = (state_q == ST_WRITE);
    bus.busy       = (state_q == ST_WAIT) || (state_q == ST_WRITE);
    bus.place_done = (state_q == ST_FINISH);
    bus.place_err  = (state_q == ST_FINISH) && (err_q != ERR_NONE);
    bus.err_code   = err_q;
    bus.address    = addr_q;
    bus.data       = data_q;
  end

endmodule

// File: tb/tb_place_piece_rmw.sv
// Directed bench for place_piece_rmw across three parameter sets.
module tb_place_piece_rmw;

  logic clk = 1'b0;
  logic resetn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  place_piece_rmw_if #(.XW(3), .YW(3), .DATA_W(4), .AW(5)) b0 ();
  place_piece_rmw_if #(.XW(3), .YW(3), .DATA_W(4), .AW(5)) b1 ();
  place_piece_rmw_if #(.XW(3), .YW(3), .DATA_W(8), .AW(4)) b2 ();

  place_piece_rmw u0 (.clk(clk), .resetn(resetn), .bus(b0));
  place_piece_rmw #(.BOARD_W(6), .BOARD_H(6)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  place_piece_rmw #(.CELLS_PER_WORD(4), .RD_LATENCY(3)) u2 (.clk(clk), .resetn(resetn), .bus(b2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b1;
    b0.place_req = 0; b0.x = 0; b0.y = 0; b0.player_black = 0; b0.q = '0;
    b1.place_req = 0; b1.x = 0; b1.y = 0; b1.player_black = 0; b1.q = '0;
    b2.place_req = 0; b2.x = 0; b2.y = 0; b2.player_black = 0; b2.q = '0;
    tick();
    tick();
    chk("rst_wren", b0.wren, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_done", b0.place_done, 0);
    chk("rst_err", b0.place_err, 0);
    chk("rst_code", b0.err_code, 0);
    chk("rst_addr", b0.address, 0);
    chk("rst_data", b0.data, 0);
    chk("rst_busy1", b1.busy, 0);
    chk("rst_done2", b2.place_done, 0);
    resetn = 1'b0;
    tick();

    // (0,0) black into an empty word
    b0.place_req = 1; b0.x = 0; b0.y = 0; b0.player_black = 1; b0.q = 4'h0;
    tick();
    chk("t1_busy", b0.busy, 1);
    chk("t1_addr", b0.address, 0);
    chk("t1_wren_wait", b0.wren, 0);
    b0.place_req = 0;
    tick();
    chk("t1_wren", b0.wren, 1);
    chk("t1_data", b0.data, 4'b0011);
    chk("t1_done_early", b0.place_done, 0);
    tick();
    chk("t1_wren_off", b0.wren, 0);
    chk("t1_done", b0.place_done, 1);
    chk("t1_err", b0.place_err, 0);
    chk("t1_code", b0.err_code, 0);
    chk("t1_busy_fin", b0.busy, 0);
    tick();
    chk("t1_done_pulse", b0.place_done, 0);

    // (3,0) white: word 1 slot 1, slot 0 preserved
    b0.place_req = 1; b0.x = 3; b0.y = 0; b0.player_black = 0; b0.q = 4'b0011;
    tick();
    chk("t2_addr", b0.address, 1);
    b0.place_req = 0;
    tick();
    chk("t2_wren", b0.wren, 1);
    chk("t2_data", b0.data, 4'b1011);
    tick();
    chk("t2_done", b0.place_done, 1);
    tick();

    // (1,0) black onto an occupied white cell
    b0.place_req = 1; b0.x = 1; b0.y = 0; b0.player_black = 1; b0.q = 4'b1000;
    tick();
    b0.place_req = 0;
    tick();
`ifdef REVERSI_OCCUPIED_CHECK_EN
    chk("t4_wren", b0.wren, 0);
    chk("t4_done", b0.place_done, 1);
    chk("t4_err", b0.place_err, 1);
    chk("t4_code", b0.err_code, 2);
    chk("t4_data_kept", b0.data, 4'b1011);
`else
    chk("t4_wren", b0.wren, 1);
    chk("t4_data", b0.data, 4'b1100);
    tick();
    chk("t4_done", b0.place_done, 1);
    chk("t4_err", b0.place_err, 0);
`endif
    tick();

    // reset while in WRITE, then a fresh request
    b0.place_req = 1; b0.x = 7; b0.y = 7; b0.player_black = 1; b0.q = 4'h0;
    tick();
    chk("t6_addr", b0.address, 31);
    b0.place_req = 0;
    tick();
    chk("t6_wren", b0.wren, 1);
    chk("t6_data", b0.data, 4'b1100);
    resetn = 1'b1;
    tick();
    chk("t6_wren_rst", b0.wren, 0);
    chk("t6_busy_rst", b0.busy, 0);
    chk("t6_done_rst", b0.place_done, 0);
    chk("t6_addr_rst", b0.address, 0);
    resetn = 1'b0;
    tick();
    chk("t6_done_after", b0.place_done, 0);
    b0.place_req = 1; b0.x = 2; b0.y = 1; b0.player_black = 0; b0.q = 4'b1100;
    tick();
    chk("t6b_addr", b0.address, 5);
    b0.place_req = 0;
    tick();
    chk("t6b_wren", b0.wren, 1);
    chk("t6b_data", b0.data, 4'b1110);
    tick();
    chk("t6b_done", b0.place_done, 1);
    tick();

    // 6x6 board: x out of range completes immediately
    b1.place_req = 1; b1.x = 6; b1.y = 0; b1.player_black = 1;
    tick();
    chk("t3_done", b1.place_done, 1);
    chk("t3_err", b1.place_err, 1);
    chk("t3_code", b1.err_code, 1);
    chk("t3_wren", b1.wren, 0);
    chk("t3_busy", b1.busy, 0);
    b1.x = 0; b1.y = 0; b1.player_black = 0; b1.q = 4'h0;
    tick();
    chk("t3_fin_ignore", b1.busy, 0);
    chk("t3_done_pulse", b1.place_done, 0);
    chk("t3_code_held", b1.err_code, 1);
    tick();
    chk("t3_accept", b1.busy, 1);
    chk("t3_code_clr", b1.err_code, 0);
    b1.place_req = 0;
    tick();
    chk("t3_wren2", b1.wren, 1);
    chk("t3_data2", b1.data, 4'b0010);
    tick();
    chk("t3_done2", b1.place_done, 1);
    chk("t3_err2", b1.place_err, 0);
    tick();
    b1.place_req = 1; b1.x = 0; b1.y = 7;
    tick();
    chk("t3_yrange", b1.err_code, 1);
    chk("t3_ydone", b1.place_err, 1);
    b1.place_req = 0;
    tick();
    b1.place_req = 1; b1.x = 5; b1.y = 5; b1.player_black = 1; b1.q = 4'b0010;
    tick();
    chk("t3_corner_addr", b1.address, 17);
    b1.place_req = 0;
    tick();
    chk("t3_corner_data", b1.data, 4'b1110);
    chk("t3_corner_wren", b1.wren, 1);
    tick();
    chk("t3_corner_done", b1.place_done, 1);
    tick();

    // latency 3, four cells per word: (5,2) -> word 5 slot 1
    b2.place_req = 1; b2.x = 5; b2.y = 2; b2.player_black = 1; b2.q = 8'hFF;
    tick();
    chk("t5_addr", b2.address, 5);
    chk("t5_busy", b2.busy, 1);
    b2.x = 0; b2.y = 0;
    tick();
    chk("t5_ignore_addr", b2.address, 5);
    chk("t5_wren_w1", b2.wren, 0);
    tick();
    chk("t5_wren_w2", b2.wren, 0);
    b2.place_req = 0; b2.q = 8'b1000_0010;
    tick();
    chk("t5_wren", b2.wren, 1);
    chk("t5_data", b2.data, 8'h8E);
    chk("t5_addr_wr", b2.address, 5);
    chk("t5_done_early", b2.place_done, 0);
    b2.q = 8'hFF;
    tick();
    chk("t5_done", b2.place_done, 1);
    chk("t5_err", b2.place_err, 0);
    tick();
    chk("t5_idle", b2.busy, 0);
    chk("t5_done_pulse", b2.place_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
